// File: rtl/muldiv_sequencer_if.sv
// Pipeline/ALU-side bundle of the multiply/divide sequencer.
// "slave" is the sequencer's view; "master" is the pipeline/ALU side.
interface muldiv_sequencer_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Cancel;
    logic        AluReq;
    logic        AluGnt;
    logic [3:0]  AluControl;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [31:0] AluResult;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport slave (
        input  Start, Op, RsData, RtData, Cancel, AluGnt, AluResult,
        output AluReq, AluControl, AluA, AluB, Busy, Done, DivByZero, Hi, Lo
    );
    modport master (
        output Start, Op, RsData, RtData, Cancel, AluGnt, AluResult,
        input  AluReq, AluControl, AluA, AluB, Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer that borrows the shared ALU one op per granted
// cycle: sign-strip, 32 shift-add / restoring-divide passes, sign fix-up, commit.
module muldiv_sequencer (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    muldiv_sequencer_if.slave     bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREP_A = 3'd1;
    localparam logic [2:0] S_PREP_B = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_FIX_LO = 3'd4;
    localparam logic [2:0] S_FIX_HI = 3'd5;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    logic [2:0]  state_q, state_d;
    // a: Rs / Pl / Q, b: Rt / M / D, w: Ph / R
    logic [31:0] a_q, a_d, b_q, b_d, w_q, w_d, lofix_q, lofix_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d, nega_q, nega_d, negb_q, negb_d;
    logic        neglo_q, neglo_d, neghi_q, neghi_d, z_q, z_d;
    logic        done_q, done_d, dbz_q, dbz_d;

    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, res, s;
    logic        sgn, sx;

    assign res = bus.AluResult;
    assign s   = {w_q[30:0], a_q[31]};
    assign sgn = ~bus.Op[0];
    assign sx  = sgn & (bus.RsData[31] ^ bus.RtData[31]);

    always_comb begin
        alu_ctl = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        case (state_q)
            S_PREP_A: begin alu_ctl = ALU_SUB; alu_b = a_q; end
            S_PREP_B: begin alu_ctl = ALU_SUB; alu_b = b_q; end
            S_ITER: begin
                if (div_q) begin
                    alu_ctl = ALU_SUB; alu_a = s; alu_b = b_q;
                end else begin
                    alu_a = w_q; alu_b = a_q[0] ? b_q : 32'd0;
                end
            end
            S_FIX_LO: begin alu_ctl = ALU_SUB; alu_b = a_q; end
            S_FIX_HI: begin
                // 64-bit negate of {Ph,Pl}: high word is ~Ph plus carry out of -Pl
                if (div_q) begin
                    alu_ctl = ALU_SUB; alu_b = w_q;
                end else begin
                    alu_a = ~w_q; alu_b = {31'b0, z_q};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q; a_d = a_q; b_d = b_q; w_d = w_q; lofix_d = lofix_q;
        hi_d = hi_q; lo_d = lo_q; cnt_d = cnt_q; div_d = div_q;
        nega_d = nega_q; negb_d = negb_q; neglo_d = neglo_q; neghi_d = neghi_q;
        z_d = z_q; done_d = 1'b0; dbz_d = 1'b0;
        if (bus.Cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.Start) begin
                    if (bus.Op[1] && bus.RtData == 32'd0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        a_d     = bus.RsData;
                        b_d     = bus.RtData;
                        div_d   = bus.Op[1];
                        nega_d  = sgn & bus.RsData[31];
                        negb_d  = sgn & bus.RtData[31];
                        neglo_d = sx;
                        neghi_d = bus.Op[1] ? (sgn & bus.RsData[31]) : sx;
                        state_d = S_PREP_A;
                    end
                end
                S_PREP_A: if (bus.AluGnt) begin
                    if (nega_q) a_d = res;
                    state_d = S_PREP_B;
                end
                S_PREP_B: if (bus.AluGnt) begin
                    if (negb_q) b_d = res;
                    w_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
                S_ITER: if (bus.AluGnt) begin
                    if (div_q) begin
                        if (w_q[31] || s >= b_q) begin
                            w_d = res; a_d = {a_q[30:0], 1'b1};
                        end else begin
                            w_d = s;   a_d = {a_q[30:0], 1'b0};
                        end
                    end else begin
                        w_d = {(res < w_q), res[31:1]};
                        a_d = {res[0], a_q[31:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = S_FIX_LO;
                end
                S_FIX_LO: if (bus.AluGnt) begin
                    lofix_d = neglo_q ? res : a_q;
                    z_d     = (a_q == 32'd0);
                    state_d = S_FIX_HI;
                end
                S_FIX_HI: if (bus.AluGnt) begin
                    hi_d    = neghi_q ? res : w_q;
                    lo_d    = lofix_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE; a_q <= '0; b_q <= '0; w_q <= '0; lofix_q <= '0;
            hi_q <= '0; lo_q <= '0; cnt_q <= '0; div_q <= 1'b0;
            nega_q <= 1'b0; negb_q <= 1'b0; neglo_q <= 1'b0; neghi_q <= 1'b0;
            z_q <= 1'b0; done_q <= 1'b0; dbz_q <= 1'b0;
        end else begin
            state_q <= state_d; a_q <= a_d; b_q <= b_d; w_q <= w_d; lofix_q <= lofix_d;
            hi_q <= hi_d; lo_q <= lo_d; cnt_q <= cnt_d; div_q <= div_d;
            nega_q <= nega_d; negb_q <= negb_d; neglo_q <= neglo_d; neghi_q <= neghi_d;
            z_q <= z_d; done_q <= done_d; dbz_q <= dbz_d;
        end
    end

    assign bus.AluReq     = (state_q != S_IDLE);
    assign bus.Busy       = (state_q != S_IDLE);
    assign bus.AluControl = alu_ctl;
    assign bus.AluA       = alu_a;
    assign bus.AluB       = alu_b;
    assign bus.Done       = done_q;
    assign bus.DivByZero  = dbz_q;
    assign bus.Hi         = hi_q;
    assign bus.Lo         = lo_q;
endmodule
